// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART transmit path.
package uart_pkg;
   localparam int DATA_W    = 8;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_GAP  = 2'b10
   } txq_state_t;
endpackage

// File: rtl/uart_txq_fifo.sv
// Circular byte buffer with occupancy count; head is read combinationally.
module uart_txq_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_ok, rd_ok;

   // A full queue drops the push even when a pop frees a slot this cycle.
   assign wr_ok = push && !full;
   assign rd_ok = pop && !empty;
   assign full  = (count == (ADDR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter over tx_start/tx_done.
// Optional UART_TXQ_IRQ_EN adds irq/irq_ack (drain and overflow interrupt).
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_ovf,
   input  logic              tx_done,
`ifdef UART_TXQ_IRQ_EN
   input  logic              irq_ack,
   output logic              irq,
`endif
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              overflow
);
   txq_state_t        state;
   logic [DATA_W-1:0] head;
   logic              pop;
   logic              done_s1, done_s2, done_hist, done_rise;

   assign pop  = (state == S_IDLE) && !empty;
   assign busy = (state != S_IDLE);

   uart_txq_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (wr_en),
      .data_in (wr_data),
      .pop     (pop),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // tx_done comes from the slow tick domain; only its rising edge matters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_s1   <= 1'b0;
         done_s2   <= 1'b0;
         done_hist <= 1'b0;
      end else begin
         done_s1   <= tx_done;
         done_s2   <= done_s1;
         done_hist <= done_s2;
      end
   end
   assign done_rise = done_s2 & ~done_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         case (state)
            S_IDLE: if (!empty) begin
               tx_data  <= head;
               tx_start <= 1'b1;
               state    <= S_REQ;
            end
            S_REQ: if (done_rise) begin
               tx_start <= 1'b0;
               state    <= S_GAP;
            end
            S_GAP:   state <= S_IDLE;
            default: begin
               tx_start <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  overflow <= 1'b0;
      else if (wr_en && full)   overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
   end

`ifdef UART_TXQ_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          irq <= 1'b0;
      else if (((state == S_GAP) && empty) || (wr_en && full)) irq <= 1'b1;
      else if (irq_ack)                                 irq <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, hand sequences and a tick-domain transmitter model.
module tb_uart_tx_queue;
   logic       clk = 0, tick = 0, rst = 1;
   logic       wr_en = 0, clr_ovf = 0;
   logic [7:0] wr_data = 0;
   logic       tx_done, tx_start, full, empty, busy, overflow;
   logic [7:0] tx_data;
   logic [4:0] count;
   logic       irq, irq_ack = 0;
   logic       model_en = 0, man_done = 0;
   logic       m_done, m_busy;
   int         m_cnt;
   int         total = 0, passed = 0, gap_err = 0;
   logic       prev_s = 0;
   logic [7:0] prev_d = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   uart_tx_queue dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .tx_done  (tx_done),
`ifdef UART_TXQ_IRQ_EN
      .irq_ack  (irq_ack),
      .irq      (irq),
`endif
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .busy     (busy),
      .overflow (overflow)
   );
`ifndef UART_TXQ_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;
   // tick = clk/16, edges offset 2 ns so they never coincide with clk edges
   initial begin
      #2;
      forever #80 tick = ~tick;
   end

   assign tx_done = model_en ? m_done : man_done;

   // Transmitter: accepts a byte on a tick, drops done, raises it 4 ticks later.
   always @(posedge tick or posedge rst) begin
      if (rst) begin
         m_done <= 0; m_busy <= 0; m_cnt <= 0;
      end else if (m_busy) begin
         if (m_cnt == 0) begin m_done <= 1; m_busy <= 0; end
         else m_cnt <= m_cnt - 1;
      end else if (model_en && tx_start) begin
         rx_q.push_back(tx_data);
         m_done <= 0; m_busy <= 1; m_cnt <= 3;
      end
   end

   // tx_start must never stay high across two different bytes.
   always @(negedge clk) begin
      if (prev_s && tx_start && tx_data != prev_d) gap_err <= gap_err + 1;
      prev_s <= tx_start;
      prev_d <= tx_data;
   end

   typedef struct {
      logic       wr; logic [7:0] d; logic clr;
      logic [4:0] cnt; logic full, empty, ovf, start;
   } vec_t;
   vec_t tbl[21];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; model_en = 0; man_done = 0; wr_en = 0; clr_ovf = 0; irq_ack = 0;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      wr_en = 1; wr_data = b;
      @(negedge clk);
      wr_en = 0;
   endtask

   task automatic wait_start(input logic lvl, input string name);
      int n = 0;
      while (tx_start !== lvl && n < 300) begin @(negedge clk); n++; end
      check(name, tx_start, lvl);
   endtask

   task automatic wait_rx(input int n, input string name);
      int k = 0;
      while (rx_q.size() < n && k < 20000) begin @(negedge clk); k++; end
      check(name, rx_q.size(), n);
   endtask

   initial begin
      // reset state (rst high from time 0)
      @(negedge clk);
      check("rst tx_start", tx_start, 0);
      check("rst tx_data", tx_data, 0);
      check("rst count", count, 0);
      check("rst empty", empty, 1);
      check("rst full", full, 0);
      check("rst busy", busy, 0);
      check("rst overflow", overflow, 0);
      rst = 0;

      // single byte with manual done pulse
      @(negedge clk);
      wr_en = 1; wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 0;
      check("a5 start latency", tx_start, 0);
      check("a5 not empty", empty, 0);
      @(negedge clk);
      check("a5 start", tx_start, 1);
      check("a5 data", tx_data, 8'hA5);
      check("a5 busy", busy, 1);
      repeat (10) @(negedge clk);
      check("a5 held", tx_start, 1);
      man_done = 1;
      wait_start(0, "a5 start drop");
      check("a5 gap busy", busy, 1);
      @(negedge clk);
      check("a5 idle busy", busy, 0);
      check("a5 idle empty", empty, 1);
      check("a5 data held", tx_data, 8'hA5);

      // three bytes through the transmitter model
      do_reset();
      rx_q.delete();
      model_en = 1;
      @(negedge clk); wr_en = 1; wr_data = 8'h01;
      @(negedge clk); wr_data = 8'h02;
      @(negedge clk); wr_data = 8'h03;
      @(negedge clk); wr_en = 0;
      wait_rx(3, "seq3 received");
      repeat (400) @(negedge clk);
      check("seq3 no dup", rx_q.size(), 3);
      for (int i = 0; i < 3 && i < rx_q.size(); i++) check("seq3 byte", rx_q[i], i + 1);

      // table: fill while stalled, overflow, clear, set-wins
      tbl[0] = '{1'b1, 8'h10, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 2; i <= 16; i++)
         tbl[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 5'(i), i == 16, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 8'hFF, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b1, 8'hEE, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[20] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         wr_en = tbl[i].wr; wr_data = tbl[i].d; clr_ovf = tbl[i].clr;
         @(negedge clk);
         wr_en = 0; clr_ovf = 0;
         if (count !== tbl[i].cnt || full !== tbl[i].full || empty !== tbl[i].empty ||
             overflow !== tbl[i].ovf || tx_start !== tbl[i].start) begin
            total++;
            $display("FAIL tbl row %0d: got cnt=%0d full=%b empty=%b ovf=%b start=%b, expected cnt=%0d full=%b empty=%b ovf=%b start=%b",
                     i, count, full, empty, overflow, tx_start,
                     tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].start);
         end else begin
            total++; passed++;
         end
      end
      rx_q.delete();
      model_en = 1;
      wait_rx(17, "fill drained");
      repeat (400) @(negedge clk);
      check("fill no dropped byte sent", rx_q.size(), 17);
      for (int i = 0; i < 17 && i < rx_q.size(); i++) check("fill byte", rx_q[i], 8'h10 + i);

      // push+pop in one cycle at count 5, then random traffic to 40 bytes
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); wr_en = 1; wr_data = 8'h30 + 8'(i);
      end
      @(negedge clk); wr_en = 0;
      check("pp count5", count, 5);
      man_done = 1;
      wait_start(0, "pp gap");
      @(negedge clk);
      wr_en = 1; wr_data = 8'h36;
      @(negedge clk);
      wr_en = 0;
      check("pp count held", count, 5);
      check("pp popped", tx_data, 8'h31);
      check("pp start", tx_start, 1);
      rx_q.delete();
      exp_q.delete();
      for (int i = 1; i <= 6; i++) exp_q.push_back(8'h30 + 8'(i));
      model_en = 1;
      begin
         int pushed = 7, k = 0;
         logic [7:0] b;
         while (pushed < 40 && k < 20000) begin
            @(negedge clk);
            wr_en = 0; k++;
            if (exp_q.size() - rx_q.size() < 15 && $urandom_range(0, 3) == 0) begin
               b = 8'($urandom);
               wr_en = 1; wr_data = b;
               exp_q.push_back(b);
               pushed++;
            end
         end
         @(negedge clk); wr_en = 0;
         check("rand pushes issued", pushed, 40);
      end
      wait_rx(exp_q.size(), "rand received");
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("rand byte", rx_q[i], exp_q[i]);
      repeat (100) @(negedge clk);
      check("rand drained empty", empty, 1);
      check("rand drained busy", busy, 0);
      check("rand overflow", overflow, 0);

      // reset while a byte is in flight with three queued
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); wr_en = 1; wr_data = 8'h41 + 8'(i);
      end
      @(negedge clk); wr_en = 0;
      check("mid count3", count, 3);
      check("mid in req", tx_start, 1);
      rst = 1;
      #1;
      check("mid rst start", tx_start, 0);
      check("mid rst count", count, 0);
      check("mid rst busy", busy, 0);
      check("mid rst empty", empty, 1);
      @(negedge clk);
      rst = 0;
      rx_q.delete();
      model_en = 1;
      push(8'h5A);
      wait_rx(1, "mid 5a received");
      if (rx_q.size() > 0) check("mid 5a byte", rx_q[0], 8'h5A);

`ifdef UART_TXQ_IRQ_EN
      do_reset();
      @(negedge clk); wr_en = 1; wr_data = 8'h61;
      @(negedge clk); wr_data = 8'h62;
      @(negedge clk); wr_en = 0;
      man_done = 1;
      wait_start(0, "irq b1 gap");
      @(negedge clk);
      check("irq not on partial drain", irq, 0);
      wait_start(1, "irq b2 start");
      man_done = 0;
      @(negedge clk);
      man_done = 1;
      wait_start(0, "irq b2 gap");
      check("irq before drain edge", irq, 0);
      @(negedge clk);
      check("irq drained", irq, 1);
      irq_ack = 1;
      @(negedge clk);
      irq_ack = 0;
      check("irq ack", irq, 0);
      push(8'h63);
      wait_start(1, "irq b3 start");
      man_done = 0;
      @(negedge clk);
      man_done = 1;
      wait_start(0, "irq b3 gap");
      irq_ack = 1;
      @(negedge clk);
      irq_ack = 0;
      check("irq set wins", irq, 1);
`endif

      check("tx_start gap between bytes", gap_err, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
